dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Data-memory access controller for the MEM stage of the pipelined core. It shares one fixed-latency data memory between the pipeline (loads/stores leaving the EX/MEM register) and an external loader/debug port. It sequences each access, generates the pipeline stall, and round-robins between the two requesters when both are waiting.

## Interface
- MEM_LAT, 2: cycles from the issue cycle (mem_en high) to mem_rdata valid; legal range 1..15.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pipe_rd_req  in  1  pipeline load request
- pipe_wr_req  in  1  pipeline store request
- pipe_addr  in  32  pipeline byte address
- pipe_wdata  in  32  pipeline store data
- pipe_stall  out  1  freeze PC/IF/ID/EX/MEM registers
- pipe_done  out  1  one-cycle pulse, pipeline access complete
- pipe_rdata  out  32  load result, valid while pipe_done=1
- ext_req  in  1  external access request
- ext_we  in  1  external write (1) / read (0)
- ext_addr  in  32  external address
- ext_wdata  in  32  external write data
- ext_gnt  out  1  external port owns memory
- ext_done  out  1  one-cycle pulse, external access complete
- ext_rdata  out  32  external read result, valid while ext_done=1
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Owner register `own` (0=pipe, 1=ext). Last-grant register `last`; reset value is ext, so the pipe wins the first tie.
- IDLE:
  - Pipe request only: latch pipe addr/wdata and we=pipe_wr_req. Set own=pipe. Go to ISSUE.
  - ext_req only: latch ext fields. Set own=ext. Go to ISSUE.
  - Both requesting: grant the requester that is not `last`.
  - Neither requesting: stay in IDLE.
  - On every grant, `last` is updated to the granted requester.
- pipe_rd_req and pipe_wr_req both high: treated as a store.
- ISSUE, one cycle:
  - mem_en=1, with mem_we/addr/wdata driven from the latched values.
  - Load the 4-bit countdown with MEM_LAT. Go to WAIT.
- WAIT:
  - Decrement the countdown each cycle.
  - In the cycle the countdown equals 1 (mem_rdata valid), capture mem_rdata into the owner's rdata register on reads, then go to RESP.
- RESP, one cycle:
  - Assert the owner's done.
  - Go to IDLE. Requests are ignored in RESP, because the pipe request still shown belongs to the completing instruction.
- Writes: done pulses as for reads; the owner's rdata register is unchanged.
- pipe_stall = (pipe_rd_req | pipe_wr_req) & ~pipe_done. This is combinational, so the pipeline advances in the RESP cycle.
- ext_gnt: high in ISSUE, WAIT and RESP when own=ext.
- Dropping ext_req or changing the pipe inputs mid-access is ignored; the latched access completes.
- Outside ISSUE, mem_en=0. mem_we/addr/wdata hold the latched values.

## Timing
- Reset, checked on a clock edge with rst=1:
  - State becomes IDLE, countdown 0, last=ext.
  - mem_en, mem_we, pipe_done, ext_done, ext_gnt all 0.
  - mem_addr, mem_wdata, pipe_rdata, ext_rdata all 0.
  - pipe_stall follows its equation (it goes high if a pipe request is present).
- Reset mid-access abandons the access: mem_en is 0 from the next cycle, no done pulse, no rdata update.
- Request seen in IDLE at cycle T:
  - ISSUE at T+1.
  - mem_rdata sampled at the end of T+1+MEM_LAT.
  - done and rdata valid at T+2+MEM_LAT.
  - Pipe stall length is MEM_LAT+2 cycles.
- Back-to-back accesses: minimum spacing between mem_en pulses is MEM_LAT+3 cycles (ISSUE, MEM_LAT WAIT cycles, RESP, IDLE).
- Countdown never wraps: WAIT always exits at count 1. MEM_LAT=1 gives exactly one WAIT cycle.

## Test plan
- Pipe load, MEM_LAT=2:
  - pipe_rd_req=1, addr=0x40 at cycle 0; memory returns 0xDEADBEEF in cycle 3.
  - Required: mem_en=1 only in cycle 1 with addr 0x40, we=0.
  - Required: pipe_done=1 and pipe_rdata=0xDEADBEEF in cycle 4.
  - Required: pipe_stall=1 in cycles 0–3 and 0 in cycle 4.
- Pipe store:
  - pipe_wr_req=1, addr=0x80, wdata=0x12345678.
  - Required: mem_en=mem_we=1 once with those values; pipe_done in cycle 4; pipe_rdata unchanged.
- Contention from reset:
  - pipe and ext both request at cycle 0 and hold.
  - Required: pipe served first (done in cycle 4), then ext (ext_gnt 6–9, ext_done in cycle 9).
  - Required: the next tie goes to pipe.
- ext_req drops in the cycle after ISSUE, with ext_we=1 and addr=0x10.
  - Required: the write still completes; ext_done pulses once; no second mem_en.
- Reset mid-access:
  - rst=1 in the second WAIT cycle of a pipe load.
  - Required: no pipe_done; all outputs 0 from the next cycle; a new request afterwards is served normally.
- Both pipe strobes high with MEM_LAT=1:
  - Required: treated as a store (mem_we=1); pipe_done in cycle 3.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle for the data-memory access controller: pipeline port,
// external loader/debug port and the fixed-latency memory port.
interface dmem_access_ctrl_if;
  // pipeline (EX/MEM) side
  logic        pipe_rd_req;
  logic        pipe_wr_req;
  logic [31:0] pipe_addr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        pipe_done;
  logic [31:0] pipe_rdata;
  // external loader/debug side
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_done;
  logic [31:0] ext_rdata;
  // data memory side
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // controller view
  modport slave (
    input  pipe_rd_req, pipe_wr_req, pipe_addr, pipe_wdata,
    output pipe_stall, pipe_done, pipe_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_done, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // requesters and memory view
  modport master (
    output pipe_rd_req, pipe_wr_req, pipe_addr, pipe_wdata,
    input  pipe_stall, pipe_done, pipe_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_done, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller. Shares one fixed-latency memory
// between the pipeline and an external port, round-robin on ties, and
// produces the pipeline stall. MEM_LAT must be in 1..15.
module dmem_access_ctrl #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_access_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = 32;
  localparam logic OWN_PIPE = 1'b0;
  localparam logic OWN_EXT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             own_q, own_d;
  logic             last_q, last_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    pipe_rdata_q, pipe_rdata_d;
  logic [DW-1:0]    ext_rdata_q, ext_rdata_d;
  logic             pipe_done_q, pipe_done_d;
  logic             ext_done_q, ext_done_d;
  logic             ext_gnt_q, ext_gnt_d;
  logic             pipe_req;

  assign pipe_req = bus.pipe_rd_req | bus.pipe_wr_req;

  // Next-state, arbitration and next values of all registered outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    own_d        = own_q;
    last_d       = last_q;
    mem_we_d     = mem_we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    pipe_rdata_d = pipe_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    mem_en_d     = 1'b0;
    pipe_done_d  = 1'b0;
    ext_done_d   = 1'b0;
    ext_gnt_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pipe_req || bus.ext_req) begin
          // pipe wins unless ext is also waiting and pipe had the last grant
          if (pipe_req && (!bus.ext_req || (last_q == OWN_EXT))) begin
            own_d    = OWN_PIPE;
            mem_we_d = bus.pipe_wr_req;
            addr_d   = bus.pipe_addr;
            wdata_d  = bus.pipe_wdata;
          end else begin
            own_d    = OWN_EXT;
            mem_we_d = bus.ext_we;
            addr_d   = bus.ext_addr;
            wdata_d  = bus.ext_wdata;
          end
          last_d    = own_d;
          state_d   = ISSUE;
          mem_en_d  = 1'b1;
          ext_gnt_d = own_d;
        end
      end

      ISSUE: begin
        cnt_d     = CNT_W'(MEM_LAT);
        state_d   = WAIT;
        ext_gnt_d = own_q;
      end

      WAIT: begin
        cnt_d     = cnt_q - 4'd1;
        ext_gnt_d = own_q;
        // count of 1 marks the cycle mem_rdata is valid
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          if (!mem_we_q) begin
            if (own_q == OWN_EXT) ext_rdata_d  = bus.mem_rdata;
            else                  pipe_rdata_d = bus.mem_rdata;
          end
          pipe_done_d = (own_q == OWN_PIPE);
          ext_done_d  = (own_q == OWN_EXT);
        end
      end

      RESP: begin
        // the pipe request still visible here belongs to the completing access
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      own_q        <= OWN_PIPE;
      last_q       <= OWN_EXT;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      pipe_rdata_q <= '0;
      ext_rdata_q  <= '0;
      pipe_done_q  <= 1'b0;
      ext_done_q   <= 1'b0;
      ext_gnt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      own_q        <= own_d;
      last_q       <= last_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      pipe_rdata_q <= pipe_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
      pipe_done_q  <= pipe_done_d;
      ext_done_q   <= ext_done_d;
      ext_gnt_q    <= ext_gnt_d;
    end
  end

  // Stall is combinational so the pipeline advances in the RESP cycle
  assign bus.pipe_stall = pipe_req & ~pipe_done_q;
  assign bus.pipe_done  = pipe_done_q;
  assign bus.pipe_rdata = pipe_rdata_q;
  assign bus.ext_gnt    = ext_gnt_q;
  assign bus.ext_done   = ext_done_q;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus randomized traffic
// against a cycle-offset reference model and a behavioural memory.
module tb_dmem_access_ctrl;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  dmem_access_ctrl_if a ();
  dmem_access_ctrl_if b ();

  dmem_access_ctrl #(.MEM_LAT(2)) dut  (.clk(clk), .rst(rst), .bus(a.slave));
  dmem_access_ctrl #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b.slave));

  always #5 clk = ~clk;

  task automatic cyc_start;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    a.pipe_rd_req = 0; a.pipe_wr_req = 0; a.pipe_addr = 0; a.pipe_wdata = 0;
    a.ext_req = 0; a.ext_we = 0; a.ext_addr = 0; a.ext_wdata = 0; a.mem_rdata = 0;
    b.pipe_rd_req = 0; b.pipe_wr_req = 0; b.pipe_addr = 0; b.pipe_wdata = 0;
    b.ext_req = 0; b.ext_we = 0; b.ext_addr = 0; b.ext_wdata = 0; b.mem_rdata = 0;
  endtask

  // leaves the caller at cycle 0 of an idle, freshly reset controller
  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) cyc_start;
    rst = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    a.pipe_rd_req = 1;
    rst = 1;
    cyc_start();
    #1;
    n_chk++;
    if ({a.mem_en, a.mem_we, a.pipe_done, a.ext_done, a.ext_gnt} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=00000", {a.mem_en, a.mem_we, a.pipe_done, a.ext_done, a.ext_gnt});
    end
    n_chk++;
    if ({a.mem_addr, a.mem_wdata, a.pipe_rdata, a.ext_rdata} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_data got=%h exp=0", {a.mem_addr, a.mem_wdata, a.pipe_rdata, a.ext_rdata});
    end
    n_chk++;
    if (a.pipe_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall_req got=%b exp=1", a.pipe_stall);
    end
    a.pipe_rd_req = 0;
    #1;
    n_chk++;
    if ({a.pipe_stall, b.mem_en, b.pipe_done, b.mem_addr} !== 35'b0) begin
      n_fail++;
      $display("FAIL reset_idle got=%h exp=0", {a.pipe_stall, b.mem_en, b.pipe_done, b.mem_addr});
    end
    cyc_start();
    rst = 0;
  endtask

  task automatic test_pipe_load;
    for (int n = 0; n <= 5; n++) begin
      if (n > 0) cyc_start();
      a.mem_rdata = (n == 3) ? 32'hDEADBEEF : 32'h0BAD0000 + 32'(n);
      if (n == 0) begin a.pipe_rd_req = 1; a.pipe_addr = 32'h40; end
      if (n == 5) a.pipe_rd_req = 0;
      #1;
      n_chk++;
      if ({a.mem_en, a.pipe_done, a.pipe_stall} !== {1'(n == 1), 1'(n == 4), 1'(n <= 3)}) begin
        n_fail++;
        $display("FAIL load_ctrl cyc=%0d got=%b exp=%b", n, {a.mem_en, a.pipe_done, a.pipe_stall},
                 {1'(n == 1), 1'(n == 4), 1'(n <= 3)});
      end
      if (n == 1) begin
        n_chk++;
        if ({a.mem_we, a.mem_addr} !== {1'b0, 32'h40}) begin
          n_fail++;
          $display("FAIL load_bus got=%h exp=%h", {a.mem_we, a.mem_addr}, {1'b0, 32'h40});
        end
      end
      if (n == 4) begin
        n_chk++;
        if (a.pipe_rdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL load_rdata got=%h exp=deadbeef", a.pipe_rdata);
        end
      end
    end
    cyc_start();
  endtask

  task automatic test_pipe_store;
    for (int n = 0; n <= 5; n++) begin
      if (n > 0) cyc_start();
      a.mem_rdata = $urandom;
      if (n == 0) begin a.pipe_wr_req = 1; a.pipe_addr = 32'h80; a.pipe_wdata = 32'h12345678; end
      if (n == 5) a.pipe_wr_req = 0;
      #1;
      n_chk++;
      if ({a.mem_en, a.pipe_done, a.pipe_stall} !== {1'(n == 1), 1'(n == 4), 1'(n <= 3)}) begin
        n_fail++;
        $display("FAIL store_ctrl cyc=%0d got=%b exp=%b", n, {a.mem_en, a.pipe_done, a.pipe_stall},
                 {1'(n == 1), 1'(n == 4), 1'(n <= 3)});
      end
      if (n == 1) begin
        n_chk++;
        if ({a.mem_we, a.mem_addr, a.mem_wdata} !== {1'b1, 32'h80, 32'h12345678}) begin
          n_fail++;
          $display("FAIL store_bus got=%h exp=%h", {a.mem_we, a.mem_addr, a.mem_wdata},
                   {1'b1, 32'h80, 32'h12345678});
        end
      end
      if (n == 4) begin
        n_chk++;
        if (a.pipe_rdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL store_rdata_kept got=%h exp=deadbeef", a.pipe_rdata);
        end
      end
    end
    cyc_start();
  endtask

  task automatic test_contention;
    logic [3:0] exp_c;
    do_reset(2);
    for (int n = 0; n <= 15; n++) begin
      if (n > 0) cyc_start();
      a.mem_rdata = 32'hC0DE0000 + 32'(n);
      if (n == 0) begin
        a.pipe_rd_req = 1; a.pipe_addr = 32'h100;
        a.ext_req = 1; a.ext_we = 0; a.ext_addr = 32'h200;
      end
      if (n == 12) begin a.pipe_rd_req = 0; a.ext_req = 0; end
      #1;
      exp_c = {1'(n == 1 || n == 6 || n == 11), 1'(n == 4 || n == 14), 1'(n == 9), 1'(n >= 6 && n <= 9)};
      n_chk++;
      if ({a.mem_en, a.pipe_done, a.ext_done, a.ext_gnt} !== exp_c) begin
        n_fail++;
        $display("FAIL cont_ctrl cyc=%0d got=%b exp=%b", n, {a.mem_en, a.pipe_done, a.ext_done, a.ext_gnt}, exp_c);
      end
      if (n == 1 || n == 6 || n == 11) begin
        n_chk++;
        if (a.mem_addr !== ((n == 6) ? 32'h200 : 32'h100)) begin
          n_fail++;
          $display("FAIL cont_addr cyc=%0d got=%h exp=%h", n, a.mem_addr, (n == 6) ? 32'h200 : 32'h100);
        end
      end
      if (n == 4 || n == 14) begin
        n_chk++;
        if (a.pipe_rdata !== 32'hC0DE0000 + 32'(n - 1)) begin
          n_fail++;
          $display("FAIL cont_prdata cyc=%0d got=%h exp=%h", n, a.pipe_rdata, 32'hC0DE0000 + 32'(n - 1));
        end
      end
      if (n == 9) begin
        n_chk++;
        if (a.ext_rdata !== 32'hC0DE0008) begin
          n_fail++;
          $display("FAIL cont_erdata got=%h exp=c0de0008", a.ext_rdata);
        end
      end
    end
    cyc_start();
  endtask

  task automatic test_ext_drop;
    for (int n = 0; n <= 6; n++) begin
      if (n > 0) cyc_start();
      a.mem_rdata = $urandom;
      if (n == 0) begin a.ext_req = 1; a.ext_we = 1; a.ext_addr = 32'h10; a.ext_wdata = 32'hCAFEF00D; end
      if (n == 2) a.ext_req = 0;
      #1;
      n_chk++;
      if ({a.mem_en, a.ext_done, a.ext_gnt} !== {1'(n == 1), 1'(n == 4), 1'(n >= 1 && n <= 4)}) begin
        n_fail++;
        $display("FAIL drop_ctrl cyc=%0d got=%b exp=%b", n, {a.mem_en, a.ext_done, a.ext_gnt},
                 {1'(n == 1), 1'(n == 4), 1'(n >= 1 && n <= 4)});
      end
      if (n == 1) begin
        n_chk++;
        if ({a.mem_we, a.mem_addr, a.mem_wdata} !== {1'b1, 32'h10, 32'hCAFEF00D}) begin
          n_fail++;
          $display("FAIL drop_bus got=%h exp=%h", {a.mem_we, a.mem_addr, a.mem_wdata}, {1'b1, 32'h10, 32'hCAFEF00D});
        end
      end
    end
    n_chk++;
    if (a.ext_rdata !== 32'hC0DE0008) begin
      n_fail++;
      $display("FAIL drop_rdata_kept got=%h exp=c0de0008", a.ext_rdata);
    end
    cyc_start();
  endtask

  task automatic test_reset_mid;
    for (int n = 0; n <= 11; n++) begin
      if (n > 0) cyc_start();
      a.mem_rdata = 32'h77770000 + 32'(n);
      if (n == 0) begin a.pipe_rd_req = 1; a.pipe_addr = 32'h44; end
      if (n == 3) rst = 1;
      if (n == 4) begin rst = 0; a.pipe_rd_req = 0; end
      if (n == 6) begin a.pipe_rd_req = 1; a.pipe_addr = 32'h48; end
      if (n == 11) a.pipe_rd_req = 0;
      #1;
      n_chk++;
      if ({a.mem_en, a.pipe_done} !== {1'(n == 1 || n == 7), 1'(n == 10)}) begin
        n_fail++;
        $display("FAIL rstmid_ctrl cyc=%0d got=%b exp=%b", n, {a.mem_en, a.pipe_done},
                 {1'(n == 1 || n == 7), 1'(n == 10)});
      end
      if (n == 4) begin
        n_chk++;
        if ({a.mem_we, a.ext_done, a.ext_gnt, a.pipe_stall, a.mem_addr, a.mem_wdata, a.pipe_rdata, a.ext_rdata} !== 132'b0) begin
          n_fail++;
          $display("FAIL rstmid_zero got=%h exp=0",
                   {a.mem_we, a.ext_done, a.ext_gnt, a.pipe_stall, a.mem_addr, a.mem_wdata, a.pipe_rdata, a.ext_rdata});
        end
      end
      if (n == 7) begin
        n_chk++;
        if (a.mem_addr !== 32'h48) begin
          n_fail++;
          $display("FAIL rstmid_addr got=%h exp=48", a.mem_addr);
        end
      end
      if (n == 10) begin
        n_chk++;
        if (a.pipe_rdata !== 32'h77770009) begin
          n_fail++;
          $display("FAIL rstmid_rdata got=%h exp=77770009", a.pipe_rdata);
        end
      end
    end
    cyc_start();
  endtask

  task automatic test_both_strobes;
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) cyc_start();
      b.mem_rdata = $urandom;
      if (n == 0) begin
        b.pipe_rd_req = 1; b.pipe_wr_req = 1; b.pipe_addr = 32'h20; b.pipe_wdata = 32'h55AA55AA;
      end
      if (n == 4) begin b.pipe_rd_req = 0; b.pipe_wr_req = 0; end
      #1;
      n_chk++;
      if ({b.mem_en, b.pipe_done, b.pipe_stall} !== {1'(n == 1), 1'(n == 3), 1'(n <= 2)}) begin
        n_fail++;
        $display("FAIL both_ctrl cyc=%0d got=%b exp=%b", n, {b.mem_en, b.pipe_done, b.pipe_stall},
                 {1'(n == 1), 1'(n == 3), 1'(n <= 2)});
      end
      if (n == 1) begin
        n_chk++;
        if ({b.mem_we, b.mem_addr, b.mem_wdata} !== {1'b1, 32'h20, 32'h55AA55AA}) begin
          n_fail++;
          $display("FAIL both_bus got=%h exp=%h", {b.mem_we, b.mem_addr, b.mem_wdata}, {1'b1, 32'h20, 32'h55AA55AA});
        end
      end
    end
    cyc_start();
  endtask

  // Random traffic. The model tracks only the grant cycle of the current
  // access; every output follows from its offset k since that grant.
  task automatic test_random;
    logic [31:0] mdl_mem [8];
    logic [31:0] env_mem [8];
    logic [31:0] g_addr, g_wdata, exp_addr, exp_wdata, exp_prd, exp_erd, rd_val;
    bit          in_fl, g_own, g_we, last_ext, exp_we, rd_pend, take_ext;
    bit          exp_en, exp_pd, exp_ed, exp_gnt, exp_stall, pr, er;
    int          g_cyc, rd_cyc, k;
    for (int i = 0; i < 8; i++) begin mdl_mem[i] = $urandom; env_mem[i] = mdl_mem[i]; end
    in_fl = 0; last_ext = 1; rd_pend = 0; rd_cyc = -1; rd_val = 0; g_cyc = 0;
    g_own = 0; g_we = 0; g_addr = 0; g_wdata = 0;
    exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_prd = 0; exp_erd = 0;
    clear_inputs();
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) cyc_start();
      a.mem_rdata = (rd_pend && c == rd_cyc) ? rd_val : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        a.pipe_rd_req = ($urandom_range(0, 2) == 0);
        a.pipe_wr_req = ($urandom_range(0, 3) == 0);
        a.pipe_addr   = $urandom & 32'hFFFF001C;
        a.pipe_wdata  = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        a.ext_req   = ($urandom_range(0, 2) == 0);
        a.ext_we    = ($urandom_range(0, 1) == 0);
        a.ext_addr  = $urandom & 32'hFFFF001C;
        a.ext_wdata = $urandom;
      end
      #1;
      k = c - g_cyc;
      exp_en  = in_fl && k == 1;
      exp_pd  = in_fl && k == LAT + 2 && !g_own;
      exp_ed  = in_fl && k == LAT + 2 && g_own;
      exp_gnt = in_fl && g_own && k >= 1 && k <= LAT + 2;
      if (exp_en && g_we) mdl_mem[g_addr[4:2]] = g_wdata;
      if ((exp_pd || exp_ed) && !g_we) begin
        if (g_own) exp_erd = mdl_mem[g_addr[4:2]];
        else       exp_prd = mdl_mem[g_addr[4:2]];
      end
      exp_stall = (a.pipe_rd_req || a.pipe_wr_req) && !exp_pd;
      n_chk++;
      if ({a.mem_en, a.pipe_done, a.ext_done, a.ext_gnt, a.pipe_stall} !== {exp_en, exp_pd, exp_ed, exp_gnt, exp_stall}) begin
        n_fail++;
        $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", c, {a.mem_en, a.pipe_done, a.ext_done, a.ext_gnt, a.pipe_stall},
                 {exp_en, exp_pd, exp_ed, exp_gnt, exp_stall});
      end
      n_chk++;
      if ({a.mem_we, a.mem_addr, a.mem_wdata} !== {exp_we, exp_addr, exp_wdata}) begin
        n_fail++;
        $display("FAIL rnd_bus cyc=%0d got=%h exp=%h", c, {a.mem_we, a.mem_addr, a.mem_wdata}, {exp_we, exp_addr, exp_wdata});
      end
      n_chk++;
      if ({a.pipe_rdata, a.ext_rdata} !== {exp_prd, exp_erd}) begin
        n_fail++;
        $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, {a.pipe_rdata, a.ext_rdata}, {exp_prd, exp_erd});
      end
      // behavioural memory reacting to the strobes actually driven
      if (a.mem_en === 1'b1) begin
        if (a.mem_we) env_mem[a.mem_addr[4:2]] = a.mem_wdata;
        else begin rd_pend = 1; rd_cyc = c + LAT; rd_val = env_mem[a.mem_addr[4:2]]; end
      end
      // arbitration happens only once the previous access has fully retired
      if (!in_fl || k >= LAT + 3) begin
        pr = a.pipe_rd_req || a.pipe_wr_req;
        er = a.ext_req;
        in_fl = pr || er;
        if (pr || er) begin
          take_ext = er && (!pr || !last_ext);
          g_cyc = c; g_own = take_ext; last_ext = take_ext;
          if (take_ext) begin g_we = a.ext_we; g_addr = a.ext_addr; g_wdata = a.ext_wdata; end
          else begin g_we = a.pipe_wr_req; g_addr = a.pipe_addr; g_wdata = a.pipe_wdata; end
          exp_we = g_we; exp_addr = g_addr; exp_wdata = g_wdata;
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_pipe_load();
    test_pipe_store();
    test_contention();
    test_ext_drop();
    test_reset_mid();
    test_both_strobes();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
